// File: rtl/trigger_monitor.sv
// trigger_monitor: locks onto a periodic trigger pulse and flags early/missing triggers while locked.
// Optional sticky error flag built only when TRIGGER_MONITOR_STICKY_EN is defined.
module trigger_monitor #(
    parameter int N        = 2,
    parameter int TOL      = 0,
    parameter int LOCK_CNT = 3,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             nul,
    input  logic             trigger,
    output logic             locked,
    output logic             err_early,
    output logic             err_late,
    output logic [CNT_W-1:0] period,
    output logic [7:0]       err_cnt,
    output logic             err_flag
);
    typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W:0] LO = (CNT_W+1)'(N - TOL);
    localparam logic [CNT_W:0] HI = (CNT_W+1)'(N + TOL);
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0] e;
    logic [GW-1:0] good, good_nx;
    logic in_rng, early, late, upd;
    // elapsed interval is one wider so a saturated counter cannot wrap
    assign e = {1'b0, cnt} + (CNT_W+1)'(1);
    assign in_rng = (e >= LO) && (e <= HI);
    always_comb begin
        state_nx = state;
        good_nx  = good;
        early    = 1'b0;
        late     = 1'b0;
        upd      = 1'b0;
        case (state)
            IDLE: begin
                if (trigger) begin
                    state_nx = ACQ;
                    good_nx  = '0;
                end
            end
            ACQ: begin
                if (trigger) begin
                    upd = 1'b1;
                    if (!in_rng) good_nx = '0;
                    else if (good == GW'(LOCK_CNT - 1)) begin
                        state_nx = LOCKED;
                        good_nx  = '0;
                    end else good_nx = good + GW'(1);
                end else if (e == HI) begin
                    state_nx = IDLE;
                    good_nx  = '0;
                end
            end
            LOCKED: begin
                if (trigger) begin
                    upd = 1'b1;
                    if (e < LO) begin
                        early    = 1'b1;
                        state_nx = ACQ;
                        good_nx  = '0;
                    end
                end else if (e == HI) begin
                    late     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            good      <= '0;
            locked    <= 1'b0;
            err_early <= 1'b0;
            err_late  <= 1'b0;
            period    <= '0;
            err_cnt   <= '0;
        end else if (!nul) begin
            state     <= IDLE;
            cnt       <= '0;
            good      <= '0;
            locked    <= 1'b0;
            err_early <= 1'b0;
            err_late  <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state     <= state_nx;
            good      <= good_nx;
            cnt       <= trigger ? '0 : (&cnt ? cnt : cnt + CNT_W'(1));
            locked    <= state_nx == LOCKED;
            err_early <= early;
            err_late  <= late;
            if (upd) period <= e[CNT_W-1:0];
            if ((early || late) && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
        end
    end
`ifdef TRIGGER_MONITOR_STICKY_EN
    always_ff @(posedge clk) begin
        if (rst || !nul) err_flag <= 1'b0;
        else if (early || late) err_flag <= 1'b1;
    end
`else
    assign err_flag = 1'b0;
`endif
endmodule

// File: tb/tb_trigger_monitor.sv
// tb_trigger_monitor: scoreboard bench for trigger_monitor (N=4, LOCK_CNT=3) with TOL=0 and TOL=1 instances.
module tb_trigger_monitor;
    logic clk = 1'b0;
    logic rst, nul, trg;
    logic lk[2], ee[2], el[2], ef[2];
    logic [7:0] per[2], ec[2];
    int checks = 0, failures = 0, cyc = 0;

    typedef struct packed {
        logic l, e, t;
        logic [7:0] p, c;
        logic f;
    } exp_t;
    exp_t q[2][$];

    int ms[2], mref[2], mg[2];
    logic [7:0] mp[2], mc[2];
    logic mf[2];
    int tol[2] = '{0, 1};
`ifdef TRIGGER_MONITOR_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    trigger_monitor #(.N(4), .TOL(0), .LOCK_CNT(3), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .nul(nul), .trigger(trg), .locked(lk[0]), .err_early(ee[0]),
        .err_late(el[0]), .period(per[0]), .err_cnt(ec[0]), .err_flag(ef[0]));
    trigger_monitor #(.N(4), .TOL(1), .LOCK_CNT(3), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .nul(nul), .trigger(trg), .locked(lk[1]), .err_early(ee[1]),
        .err_late(el[1]), .period(per[1]), .err_cnt(ec[1]), .err_flag(ef[1]));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    // reference: elapsed time measured from the cycle of the last reference trigger
    task automatic model(input int i);
        int e;
        bit early = 0, late = 0;
        exp_t x;
        e = cyc - mref[i];
        if (e > 256) e = 256;
        if (rst || !nul) begin
            ms[i] = 0; mref[i] = cyc; mg[i] = 0; mc[i] = 0; mf[i] = 0;
            if (rst) mp[i] = 0;
        end else begin
            if (trg) mref[i] = cyc;
            if (ms[i] == 0) begin
                if (trg) begin ms[i] = 1; mg[i] = 0; end
            end else if (ms[i] == 1) begin
                if (trg) begin
                    mp[i] = 8'(e);
                    if (e >= 4 - tol[i] && e <= 4 + tol[i]) begin
                        mg[i]++;
                        if (mg[i] == 3) begin ms[i] = 2; mg[i] = 0; end
                    end else mg[i] = 0;
                end else if (e == 4 + tol[i]) begin ms[i] = 0; mg[i] = 0; end
            end else begin
                if (trg) begin
                    mp[i] = 8'(e);
                    if (e < 4 - tol[i]) begin early = 1; ms[i] = 1; mg[i] = 0; end
                end else if (e == 4 + tol[i]) begin late = 1; ms[i] = 0; end
            end
            if ((early || late) && mc[i] != 8'd255) mc[i]++;
            if ((early || late) && STICKY) mf[i] = 1;
        end
        x = '{l: ms[i] == 2, e: early, t: late, p: mp[i], c: mc[i], f: mf[i]};
        q[i].push_back(x);
    endtask

    task automatic step(input logic r, input logic n, input logic t);
        exp_t x;
        rst = r; nul = n; trg = t;
        model(0);
        model(1);
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            x = q[i].pop_front();
            check($sformatf("locked%0d", i), 32'(lk[i]), 32'(x.l));
            check($sformatf("err_early%0d", i), 32'(ee[i]), 32'(x.e));
            check($sformatf("err_late%0d", i), 32'(el[i]), 32'(x.t));
            check($sformatf("period%0d", i), 32'(per[i]), 32'(x.p));
            check($sformatf("err_cnt%0d", i), 32'(ec[i]), 32'(x.c));
            check($sformatf("err_flag%0d", i), 32'(ef[i]), 32'(x.f));
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 1, 0);
    endtask

    task automatic pulse(input int g);
        idle(g - 1);
        step(0, 1, 1);
    endtask

    initial begin
        rst = 1; nul = 1; trg = 0;
        step(1, 1, 0);
        step(1, 1, 1);
        check("rst_locked", 32'(lk[0]), 0);
        check("rst_period", 32'(per[0]), 0);
        idle(5);
        // lock with period 4
        pulse(1); pulse(4); pulse(4);
        check("acq_not_locked", 32'(lk[0]), 0);
        pulse(4);
        check("lock", 32'(lk[0]), 1);
        check("lock_period", 32'(per[0]), 4);
        // early trigger
        pulse(3);
        check("early_pulse", 32'(ee[0]), 1);
        check("early_unlock", 32'(lk[0]), 0);
        check("early_tol1_stays", 32'(lk[1]), 1);
        check("early_cnt", 32'(ec[0]), 1);
        check("early_period", 32'(per[0]), 3);
        idle(1);
        check("early_one_cycle", 32'(ee[0]), 0);
        idle(2);
        step(0, 1, 1);
        pulse(4); pulse(4);
        check("relock", 32'(lk[0]), 1);
        check("sticky_held", 32'(ef[0]), 32'(STICKY));
        // missing trigger
        idle(4);
        check("late_pulse", 32'(el[0]), 1);
        check("late_unlock", 32'(lk[0]), 0);
        idle(12);
        pulse(1);
        check("after_late_acq_only", 32'(ee[0] | el[0] | lk[0]), 0);
        pulse(4); pulse(4); pulse(4);
        check("relock2", 32'(lk[0]), 1);
        // clear with simultaneous trigger
        idle(3);
        step(0, 0, 1);
        check("nul_locked", 32'(lk[0]), 0);
        check("nul_errcnt", 32'(ec[0]), 0);
        check("nul_period", 32'(per[0]), 4);
        check("nul_flag", 32'(ef[0]), 0);
        idle(6);
        pulse(1); pulse(4); pulse(4); pulse(4);
        // tolerance intervals 3,5,4 then deadline, then many early errors
        idle(8);
        pulse(1); pulse(3); pulse(5); pulse(4);
        check("tol_lock", 32'(lk[1]), 1);
        idle(5);
        check("tol_late", 32'(el[1]), 1);
        pulse(1);
        for (int k = 0; k < 300; k++) begin
            pulse(4); pulse(4); pulse(4); pulse(2);
        end
        check("sat_cnt", 32'(ec[1]), 255);
        check("sat_cnt0", 32'(ec[0]), 255);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/trigger_monitor.md
Name: trigger_monitor

Overview:
Receive-side checker for the periodic one-cycle trigger pulse produced by the counter-based trigger generator. It measures the interval between trigger pulses and acquires lock after LOCK_CNT consecutive in-tolerance intervals. While locked it flags early and missing (late) triggers. It sits at the consumer end of the trigger line and gives downstream logic a qualified locked indication plus error statistics.

Parameters:
N, 2, expected trigger period in clk cycles (N >= 1)
TOL, 0, allowed deviation in cycles; an interval is good if N-TOL <= interval <= N+TOL (TOL < N)
LOCK_CNT, 3, consecutive good intervals required to lock (>= 1)
CNT_W, 8, width of the interval counter and period output (N+TOL < 2**CNT_W)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
nul  input  1  active-low synchronous clear; low returns the block to IDLE
trigger  input  1  trigger pulse from the generator, sampled on clk
locked  output  1  registered; high while in LOCKED
err_early  output  1  registered one-cycle pulse: trigger arrived early while locked
err_late  output  1  registered one-cycle pulse: trigger missing at deadline while locked
period  output  CNT_W  last measured interval, registered
err_cnt  output  8  saturating count of early+late errors
err_flag  output  1  sticky error flag (see Optional Feature)

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; cnt=0; good=0; locked=0; err_early=0; err_late=0; period=0; err_cnt=0; err_flag=0.
- Priority: rst > nul low > trigger/timeout logic.
- nul=0: state=IDLE, cnt=0, good=0, err_cnt=0, err_flag=0, err pulses=0; period holds its value; trigger in the same cycle is ignored.
- Interval counter cnt: set to 0 on a trigger cycle; otherwise cnt+1, saturating at 2**CNT_W-1. Elapsed interval in any cycle is E = cnt+1. A generator with period N produces E = N on each trigger.
- IDLE: trigger -> ACQ, cnt=0, good=0. No period update.
- ACQ, trigger:
  - period <= E.
  - If E is in range: good+1. When good+1 == LOCK_CNT -> LOCKED.
  - If E is out of range: good=0 and stay in ACQ.
  - No error pulses are raised in ACQ.
- ACQ, no trigger with E == N+TOL: -> IDLE, good=0, no error pulse.
- LOCKED, trigger:
  - period <= E.
  - If E < N-TOL: err_early=1 next cycle; err_cnt+1; -> ACQ with good=0. This trigger becomes the new reference (cnt=0).
  - Otherwise stay LOCKED.
- LOCKED, no trigger with E == N+TOL: err_late=1 next cycle; err_cnt+1; -> IDLE.
- locked = (state==LOCKED). It asserts the cycle after the LOCK_CNT-th good trigger and deasserts the cycle after an error or nul low.
- err_early and err_late are never high together. Each is high for exactly one cycle per event.
- err_cnt saturates at 255.
- Latency: all outputs are registered, 1 cycle after the causing trigger or deadline cycle.

Optional Feature:
Macro TRIGGER_MONITOR_STICKY_EN.
- Defined: err_flag sets on any err_early or err_late pulse (same cycle as the pulse) and holds until rst or nul low.
- Undefined: the port is present but err_flag is tied to 0, and the sticky register is not built.

Test Plan:
1. N=4, TOL=0, LOCK_CNT=3; triggers at cycles 10,14,18,22 -> ACQ after 10; locked=1 from cycle 23; period=4; no error pulses.
2. Locked as in 1, next trigger at cycle 25 (E=3) -> err_early=1 at cycle 26 only; locked=0 at 26; err_cnt=1; period=3; triggers at 29,33,37 -> locked=1 at 38.
3. Locked as in 1, no trigger after 22 -> at cycle 26 (E=4) err_late=1 at cycle 27; locked=0 at 27; err_cnt=1; later trigger at 40 -> ACQ only, no error.
4. Locked as in 1; nul=0 at cycle 30 together with trigger -> cycle 31: locked=0, err_cnt=0, period unchanged; trigger ignored, next trigger restarts IDLE->ACQ.
5. N=4, TOL=1; intervals 3,5,4 -> locked; then no trigger -> err_late at E=5 deadline +1 cycle; then 300 forced early errors -> err_cnt=255.
6. TRIGGER_MONITOR_STICKY_EN defined, scenario 2 -> err_flag=1 from cycle 26 and held through relock until nul=0; undefined -> err_flag stays 0.
